// File: rtl/operand_fetch_stage.sv
// Issue stage: reads operands with write-back forwarding, stalls RAW/WAW hazards
// against a pending-write scoreboard, and hands a registered bundle to execute.
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs_a,
    input  logic [ADDR_W-1:0] in_rs_b,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    output logic [ADDR_W-1:0] a_select,
    output logic [ADDR_W-1:0] b_select,
    input  logic [DATA_W-1:0] port_a,
    input  logic [DATA_W-1:0] port_b,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b
);
    localparam int NREG = 1 << ADDR_W;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } bundle_t;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t          state, state_nxt;
    bundle_t         out_q, out_d;
    logic [NREG-1:0] busy, busy_nxt;
    logic            fwd_a, fwd_b, fwd_d;
    logic            stall, accept, load;

    assign a_select = in_rs_a;
    assign b_select = in_rs_b;

    assign fwd_a = wb_en && (wb_addr == in_rs_a);
    assign fwd_b = wb_en && (wb_addr == in_rs_b);
    assign fwd_d = wb_en && (wb_addr == in_rd);

    // A busy register being written back this cycle is no longer a hazard.
    assign stall = in_valid && ((busy[in_rs_a] && !fwd_a) ||
                                (busy[in_rs_b] && !fwd_b) ||
                                (in_we && busy[in_rd] && !fwd_d));

    assign out_valid = (state == S_FULL);
    assign in_ready  = !stall && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_FULL;
                    load      = 1'b1;
                end
            end
            S_FULL: begin
                if (accept) begin
                    load = 1'b1;
                end else if (out_ready) begin
                    state_nxt = S_EMPTY;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        out_d.op = in_op;
        out_d.rd = in_rd;
        out_d.we = in_we;
        out_d.a  = fwd_a ? wb_data : port_a;
        out_d.b  = fwd_b ? wb_data : port_b;
    end

    // Clear first, then set, so a new writer to the retiring register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_en)
            busy_nxt[wb_addr] = 1'b0;
        if (accept && in_we)
            busy_nxt[in_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            out_q <= '0;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            if (load)
                out_q <= out_d;
        end
    end

    assign out_op = out_q.op;
    assign out_rd = out_q.rd;
    assign out_we = out_q.we;
    assign out_a  = out_q.a;
    assign out_b  = out_q.b;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic
// against a scoreboard model, with a simple register file behind the read ports.
module tb_operand_fetch_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   in_op = '0;
    logic [ADDR_W-1:0] in_rs_a = '0, in_rs_b = '0, in_rd = '0;
    logic              in_we = 1'b0;
    logic [ADDR_W-1:0] a_select, b_select;
    logic [DATA_W-1:0] port_a, port_b;
    logic              wb_en = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_rd;
    logic              out_we;
    logic [DATA_W-1:0] out_a, out_b;

    int n_vec = 0;
    int n_err = 0;

    operand_fetch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_we(in_we),
        .a_select(a_select), .b_select(b_select), .port_a(port_a), .port_b(port_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_we(out_we), .out_a(out_a), .out_b(out_b)
    );

    always #5 clk = ~clk;

    // Register file behind the stage: combinational read, write on wb_en.
    logic [DATA_W-1:0] rf [16];
    assign port_a = rf[a_select];
    assign port_b = rf[b_select];
    always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

    // Reference model state
    bit                m_busy [16];
    bit                m_vld;
    logic [OP_W-1:0]   m_op;
    logic [ADDR_W-1:0] m_rd;
    logic              m_we;
    logic [DATA_W-1:0] m_a, m_b;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int op, input int ra, input int rb,
                          input int rd, input bit we);
        in_valid = v;
        in_op    = OP_W'(op);
        in_rs_a  = ADDR_W'(ra);
        in_rs_b  = ADDR_W'(rb);
        in_rd    = ADDR_W'(rd);
        in_we    = we;
    endtask

    task automatic set_wb(input bit en, input int addr, input logic [DATA_W-1:0] data);
        wb_en   = en;
        wb_addr = ADDR_W'(addr);
        wb_data = data;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (dut.busy !== 16'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", dut.busy); end
        n_vec++; if ({out_op, out_rd, out_we, out_a, out_b} !== '0) begin n_err++; $display("FAIL reset_out_regs: got nonzero op=%h a=%h b=%h", out_op, out_a, out_b); end
        set_in(1, 5, 1, 2, 0, 0);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL first_accept_ready: got %b want 1", in_ready); end
        n_vec++; if (a_select !== 4'd1 || b_select !== 4'd2) begin n_err++; $display("FAIL first_selects: got %0d/%0d want 1/2", a_select, b_select); end
        clk_step();
        set_in(0, 0, 0, 0, 0, 0);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_op !== 6'd5) begin n_err++; $display("FAIL first_out_op: got %0d want 5", out_op); end
        n_vec++; if (out_a !== rf[1] || out_b !== rf[2]) begin n_err++; $display("FAIL first_operands: got %h/%h want %h/%h", out_a, out_b, rf[1], rf[2]); end
        clk_step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_raw_stall();
        set_in(1, 1, 0, 0, 3, 1);
        clk_step();
        set_in(1, 2, 3, 5, 8, 0);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_0: got %b want 0", in_ready); end
        clk_step();
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL raw_stall_1: got ready=%b valid=%b want 0/0", in_ready, out_valid); end
        set_wb(1, 3, 32'hDEADBEEF);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", in_ready); end
        clk_step();
        set_wb(0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        n_vec++; if (out_valid !== 1'b1 || out_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_forward: got valid=%b a=%h want 1/deadbeef", out_valid, out_a); end
        n_vec++; if (out_op !== 6'd2 || out_b !== rf[5]) begin n_err++; $display("FAIL raw_bundle: got op=%0d b=%h want 2/%h", out_op, out_b, rf[5]); end
        n_vec++; if (dut.busy[3] !== 1'b0) begin n_err++; $display("FAIL raw_busy_clear: got %b want 0", dut.busy[3]); end
        clk_step();
    endtask

    task automatic test_waw_stall();
        set_in(1, 3, 0, 0, 7, 1);
        clk_step();
        set_in(1, 4, 0, 0, 7, 1);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall_0: got %b want 0", in_ready); end
        clk_step();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall_1: got %b want 0", in_ready); end
        set_wb(1, 7, 32'h0000_7777);
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL waw_release: got %b want 1", in_ready); end
        clk_step();
        set_wb(0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        n_vec++; if (dut.busy[7] !== 1'b1) begin n_err++; $display("FAIL waw_set_wins: got %b want 1", dut.busy[7]); end
        n_vec++; if (out_valid !== 1'b1 || out_op !== 6'd4 || out_rd !== 4'd7 || out_we !== 1'b1) begin n_err++; $display("FAIL waw_bundle: got v=%b op=%0d rd=%0d we=%b want 1/4/7/1", out_valid, out_op, out_rd, out_we); end
        set_wb(1, 7, 32'h0000_7778);
        clk_step();
        set_wb(0, 0, 0);
        n_vec++; if (dut.busy[7] !== 1'b0) begin n_err++; $display("FAIL waw_final_clear: got %b want 0", dut.busy[7]); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1, 6, 1, 2, 0, 0);
        clk_step();
        set_in(1, 7, 4, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
            n_vec++; if (out_valid !== 1'b1 || out_op !== 6'd6 || out_a !== rf[1] || out_b !== rf[2]) begin n_err++; $display("FAIL bp_hold_%0d: got v=%b op=%0d a=%h b=%h want 1/6/%h/%h", i, out_valid, out_op, out_a, out_b, rf[1], rf[2]); end
            clk_step();
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", in_ready); end
        clk_step();
        set_in(0, 0, 0, 0, 0, 0);
        n_vec++; if (out_valid !== 1'b1 || out_op !== 6'd7 || out_a !== rf[4] || out_b !== rf[5]) begin n_err++; $display("FAIL bp_b2b_load: got v=%b op=%0d a=%h b=%h want 1/7/%h/%h", out_valid, out_op, out_a, out_b, rf[4], rf[5]); end
        clk_step();
    endtask

    task automatic test_fwd_both();
        set_in(1, 9, 4, 4, 0, 0);
        set_wb(1, 4, 32'h0000_1234);
        clk_step();
        set_wb(0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        n_vec++; if (out_a !== 32'h1234 || out_b !== 32'h1234) begin n_err++; $display("FAIL fwd_both: got %h/%h want 1234/1234", out_a, out_b); end
        clk_step();
    endtask

    task automatic test_async_reset();
        set_in(1, 1, 0, 0, 9, 1);
        clk_step();
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        n_vec++; if (out_valid !== 1'b1 || dut.busy[9] !== 1'b1) begin n_err++; $display("FAIL arst_setup: got v=%b busy9=%b want 1/1", out_valid, dut.busy[9]); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || dut.busy !== 16'h0) begin n_err++; $display("FAIL arst_async: got v=%b busy=%h want 0/0", out_valid, dut.busy); end
        n_vec++; if (out_rd !== 4'd0 || out_we !== 1'b0 || out_op !== 6'd0) begin n_err++; $display("FAIL arst_regs: got rd=%0d we=%b op=%0d want 0", out_rd, out_we, out_op); end
        rst_n = 1'b1;
        set_wb(1, 9, 32'h0000_9999);
        clk_step();
        set_wb(0, 0, 0);
        n_vec++; if (dut.busy !== 16'h0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst_stale_wb: got busy=%h ready=%b want 0/1", dut.busy, in_ready); end
    endtask

    function automatic bit pending(input logic [ADDR_W-1:0] r);
        return m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    task automatic test_random();
        bit                m_ready;
        bit                acc;
        int                s;
        rst_n = 1'b0;
        foreach (m_busy[k]) m_busy[k] = 1'b0;
        m_vld = 1'b0;
        clk_step();
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(9) < 7, int'($urandom_range(63)), int'($urandom_range(15)),
                   int'($urandom_range(15)), int'($urandom_range(15)), $urandom_range(1) == 1);
            out_ready = ($urandom_range(9) < 7);
            wb_en     = ($urandom_range(9) < 4);
            wb_addr   = ADDR_W'($urandom_range(15));
            wb_data   = $urandom;
            if ($urandom_range(1) == 1) begin
                s = int'($urandom_range(15));
                for (int k = 0; k < 16; k++) begin
                    if (m_busy[(s + k) % 16]) begin
                        wb_addr = ADDR_W'((s + k) % 16);
                        break;
                    end
                end
            end
            @(negedge clk);
            m_ready = !(in_valid && (pending(in_rs_a) || pending(in_rs_b) || (in_we && pending(in_rd))))
                      && (!m_vld || out_ready);
            n_vec++; if (a_select !== in_rs_a || b_select !== in_rs_b) begin n_err++; $display("FAIL rnd_select[%0d]: got %0d/%0d want %0d/%0d", i, a_select, b_select, in_rs_a, in_rs_b); end
            n_vec++; if (in_ready !== m_ready) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, m_ready); end
            n_vec++; if (out_valid !== m_vld) begin n_err++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, out_valid, m_vld); end
            if (m_vld) begin
                n_vec++; if ({out_op, out_rd, out_we} !== {m_op, m_rd, m_we}) begin n_err++; $display("FAIL rnd_ctl[%0d]: got op=%0d rd=%0d we=%b want %0d/%0d/%b", i, out_op, out_rd, out_we, m_op, m_rd, m_we); end
                n_vec++; if (out_a !== m_a || out_b !== m_b) begin n_err++; $display("FAIL rnd_operands[%0d]: got %h/%h want %h/%h", i, out_a, out_b, m_a, m_b); end
            end
            acc = in_valid && m_ready;
            if (acc) begin
                m_vld = 1'b1;
                m_op  = in_op;
                m_rd  = in_rd;
                m_we  = in_we;
                m_a   = (wb_en && wb_addr == in_rs_a) ? wb_data : rf[in_rs_a];
                m_b   = (wb_en && wb_addr == in_rs_b) ? wb_data : rf[in_rs_b];
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (acc && in_we) m_busy[in_rd] = 1'b1;
            clk_step();
        end
        set_in(0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = 32'hCAFE0000 | r;
        repeat (2) clk_step();
        rst_n = 1'b1;
        test_reset();
        test_raw_stall();
        test_waw_stall();
        test_backpressure();
        test_fwd_both();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
